seq1010_scan_ctrl: RTL

- Word-level controller for the team's serial 1010 Mealy sequence detector.
- Accepts parallel words over a valid/ready handshake and serializes them MSB-first into an embedded 1010 detector FSM, one bit per clock.
- Counts matches and raises a sticky interrupt at a programmable threshold.
- Sits between a byte-wide producer and status/interrupt logic.

---
 rtl/seq1010_scan_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/seq1010_scan_ctrl.sv
// Word-level front end for the serial 1010 Mealy detector: words arrive over valid/ready,
// are scanned MSB-first one bit per clock, and matches are counted toward a sticky interrupt.
module seq1010_scan_ctrl #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned OVERLAP = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clear,
    input  logic [CNT_W-1:0]  threshold,
    output logic              busy,
    output logic              match_pulse,
    output logic [CNT_W-1:0]  match_count,
    output logic              irq
);

    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        IDLE,
        SHIFT
    } ctrl_e;

    typedef enum logic [1:0] {
        S0,
        S1,
        S10,
        S101
    } det_e;

    ctrl_e             ctrl_q, ctrl_d;
    det_e              det_q, det_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              pulse_q, pulse_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              irq_q, irq_d;

    logic handshake;
    logic bit_in;
    logic match;

    // Ready is combinational so a new word can be taken on the last bit of the current one.
    assign in_ready    = reset && ((ctrl_q == IDLE) || (bit_idx_q == LAST_IDX));
    assign busy        = (ctrl_q == SHIFT);
    assign match_pulse = pulse_q;
    assign match_count = count_q;
    assign irq         = irq_q;

    assign handshake = in_valid && in_ready;
    assign bit_in    = shreg_q[DATA_W-1];

    always_comb begin
        ctrl_d    = ctrl_q;
        det_d     = det_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        pulse_d   = 1'b0;
        count_d   = count_q;
        irq_d     = irq_q;
        match     = 1'b0;

        case (ctrl_q)
            IDLE: begin
                if (handshake) begin
                    shreg_d   = in_data;
                    bit_idx_d = '0;
                    ctrl_d    = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d   = shreg_q << 1;
                bit_idx_d = bit_idx_q + IDX_W'(1);
                case (det_q)
                    S0:   det_d = bit_in ? S1 : S0;
                    S1:   det_d = bit_in ? S1 : S10;
                    S10:  det_d = bit_in ? S101 : S0;
                    S101: begin
                        if (bit_in) begin
                            det_d = S1;
                        end else begin
                            match = 1'b1;
                            det_d = (OVERLAP != 0) ? S10 : S0;
                        end
                    end
                    default: det_d = S0;
                endcase
                if (bit_idx_q == LAST_IDX) begin
                    bit_idx_d = '0;
                    if (handshake) begin
                        shreg_d = in_data;
                    end else begin
                        ctrl_d = IDLE;
                    end
                end
            end
            default: ctrl_d = IDLE;
        endcase

        // Saturating count; pulse still fires when the counter is pinned.
        if (match) begin
            pulse_d = 1'b1;
            if (count_q != CNT_MAX) begin
                count_d = count_q + CNT_W'(1);
            end
            if ((threshold != '0) && (count_d == threshold)) begin
                irq_d = 1'b1;
            end
        end

        // Clear overrides a coincident match but leaves the word in flight running.
        if (clear) begin
            count_d = '0;
            irq_d   = 1'b0;
            pulse_d = 1'b0;
            det_d   = S0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q    <= IDLE;
            det_q     <= S0;
            shreg_q   <= '0;
            bit_idx_q <= '0;
            pulse_q   <= 1'b0;
            count_q   <= '0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            det_q     <= det_d;
            shreg_q   <= shreg_d;
            bit_idx_q <= bit_idx_d;
            pulse_q   <= pulse_d;
            count_q   <= count_d;
            irq_q     <= irq_d;
        end
    end

endmodule
